// File: rtl/icache_if.sv
// Fetcher-side and memory-side signal bundle for the instruction cache.
// The slave modport is the cache's view; the master modport is the environment's view.
interface icache_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  clear_in;
  logic                  fetch_valid_in;
  logic [ADDR_WIDTH-1:0] fetch_pc_in;
  logic                  ready_out;
  logic                  inst_valid_out;
  logic [31:0]           inst_out;
  logic [ADDR_WIDTH-1:0] inst_pc_out;
  logic                  mem_req_out;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic                  mem_done_in;
  logic [31:0]           mem_data_in;

  modport slave (
    input  clear_in, fetch_valid_in, fetch_pc_in, mem_done_in, mem_data_in,
    output ready_out, inst_valid_out, inst_out, inst_pc_out, mem_req_out, mem_addr_out
  );

  modport master (
    output clear_in, fetch_valid_in, fetch_pc_in, mem_done_in, mem_data_in,
    input  ready_out, inst_valid_out, inst_out, inst_pc_out, mem_req_out, mem_addr_out
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache with one-word lines and a single outstanding miss.
// Hits return one cycle later; misses fetch one word from memory, fill, then return it.
module icache #(
  parameter int unsigned INDEX_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  icache_if.slave  bus
);
  localparam int unsigned Lines    = 1 << INDEX_WIDTH;
  localparam int unsigned TagWidth = ADDR_WIDTH - INDEX_WIDTH - 2;

  typedef enum logic {StIdle, StMiss} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  drop_q, drop_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [31:0]           inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  logic [Lines-1:0]    valid_q;
  logic [TagWidth-1:0] tag_q [Lines];
  logic [31:0]         data_q [Lines];

  logic [INDEX_WIDTH-1:0] req_idx, fill_idx;
  logic [TagWidth-1:0]    req_tag, fill_tag;
  logic                   hit;
  logic                   fill_en;

  assign req_idx  = bus.fetch_pc_in[INDEX_WIDTH+1:2];
  assign req_tag  = bus.fetch_pc_in[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign fill_idx = pc_q[INDEX_WIDTH+1:2];
  assign fill_tag = pc_q[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_valid_d = 1'b0;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    fill_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.fetch_valid_in && !bus.clear_in) begin
          if (hit) begin
            inst_valid_d = 1'b1;
            inst_d       = data_q[req_idx];
            inst_pc_d    = bus.fetch_pc_in;
          end else begin
            state_d    = StMiss;
            pc_d       = bus.fetch_pc_in;
            drop_d     = 1'b0;
            mem_req_d  = 1'b1;
            mem_addr_d = {bus.fetch_pc_in[ADDR_WIDTH-1:2], 2'b00};
          end
        end
      end
      StMiss: begin
        // The controller cannot abort, so a flush only suppresses the eventual delivery.
        if (bus.clear_in) drop_d = 1'b1;
        if (bus.mem_done_in) begin
          fill_en   = 1'b1;
          state_d   = StIdle;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          if (!drop_q && !bus.clear_in) begin
            inst_valid_d = 1'b1;
            inst_d       = bus.mem_data_in;
            inst_pc_d    = pc_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      valid_q      <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      if (fill_en) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless while the valid bit is clear, so no reset here.
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.mem_data_in;
    end
  end

  assign bus.ready_out      = (state_q == StIdle);
  assign bus.inst_valid_out = inst_valid_q;
  assign bus.inst_out       = inst_q;
  assign bus.inst_pc_out    = inst_pc_q;
  assign bus.mem_req_out    = mem_req_q;
  assign bus.mem_addr_out   = mem_addr_q;
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: vector table of fetches plus hand-written flush,
// pause and reset sequences; delivered instructions are checked against a scoreboard.
module tb_icache;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;

  icache_if #(.ADDR_WIDTH(32)) bus ();

  icache #(.INDEX_WIDTH(8), .ADDR_WIDTH(32)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    bit          hit;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0513;
      32'h0000_0010: return 32'hDEAD_BEEF;
      default:       return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Delivered instructions are popped from the scoreboard on the falling edge.
  always @(negedge clk_in) begin : monitor
    exp_t e;
    if (bus.inst_valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_inst: got inst %h pc %h, expected no delivery (t=%0t)",
                 bus.inst_out, bus.inst_pc_out, $time);
      end else begin
        e = sb.pop_front();
        check("inst_out", bus.inst_out, e.inst);
        check("inst_pc_out", bus.inst_pc_out, e.pc);
      end
    end
  end

  task automatic fetch(input logic [31:0] pc, input bit exp_hit, input int lat);
    exp_t e;
    check("ready_before_fetch", {31'd0, bus.ready_out}, 32'd1);
    bus.fetch_valid_in = 1'b1;
    bus.fetch_pc_in    = pc;
    if (exp_hit) begin
      e.inst = mem_word(pc);
      e.pc   = pc;
      sb.push_back(e);
    end
    step();
    bus.fetch_valid_in = 1'b0;
    if (exp_hit) begin
      check("hit_no_mem_req", {31'd0, bus.mem_req_out}, 32'd0);
    end else begin
      check("miss_mem_req", {31'd0, bus.mem_req_out}, 32'd1);
      check("miss_mem_addr", bus.mem_addr_out, {pc[31:2], 2'b00});
      check("miss_ready_low", {31'd0, bus.ready_out}, 32'd0);
      for (int i = 0; i < lat; i++) begin
        step();
        check("miss_req_held", {31'd0, bus.mem_req_out}, 32'd1);
        check("miss_addr_held", bus.mem_addr_out, {pc[31:2], 2'b00});
      end
      bus.mem_done_in = 1'b1;
      bus.mem_data_in = mem_word({pc[31:2], 2'b00});
      e.inst = bus.mem_data_in;
      e.pc   = pc;
      sb.push_back(e);
      step();
      bus.mem_done_in = 1'b0;
      check("fill_req_drop", {31'd0, bus.mem_req_out}, 32'd0);
      check("fill_ready", {31'd0, bus.ready_out}, 32'd1);
    end
  endtask

  vec_t vecs [12];

  initial begin
    vecs = '{
      '{32'h0000_0000, 1'b0, 3},  // cold miss
      '{32'h0000_0000, 1'b1, 0},  // back-to-back hits
      '{32'h0000_0000, 1'b1, 0},
      '{32'h0000_0004, 1'b0, 2},
      '{32'h0000_0404, 1'b0, 1},  // same index as 0x4
      '{32'h0000_0004, 1'b0, 0},
      '{32'h0000_0404, 1'b0, 2},
      '{32'h0000_0404, 1'b1, 0},
      '{32'h0000_0008, 1'b0, 1},
      '{32'h0000_0008, 1'b1, 0},
      '{32'h0000_03FC, 1'b0, 1},
      '{32'hFFFF_FFFC, 1'b0, 2}   // last index, different tag
    };

    bus.clear_in       = 1'b0;
    bus.fetch_valid_in = 1'b0;
    bus.fetch_pc_in    = '0;
    bus.mem_done_in    = 1'b0;
    bus.mem_data_in    = '0;

    repeat (3) step();
    check("rst_ready", {31'd0, bus.ready_out}, 32'd1);
    check("rst_inst_valid", {31'd0, bus.inst_valid_out}, 32'd0);
    check("rst_mem_req", {31'd0, bus.mem_req_out}, 32'd0);
    check("rst_mem_addr", bus.mem_addr_out, 32'd0);
    check("rst_inst", bus.inst_out, 32'd0);
    check("rst_inst_pc", bus.inst_pc_out, 32'd0);
    rst_in = 1'b1;

    foreach (vecs[i]) fetch(vecs[i].pc, vecs[i].hit, vecs[i].lat);
    fetch(32'h0000_03FC, 1'b0, 1);

    // Flush two cycles into a miss: line still fills, nothing is delivered.
    bus.fetch_valid_in = 1'b1;
    bus.fetch_pc_in    = 32'h0000_0010;
    step();
    bus.fetch_valid_in = 1'b0;
    step();
    bus.clear_in = 1'b1;
    step();
    bus.clear_in = 1'b0;
    check("flush_req_kept", {31'd0, bus.mem_req_out}, 32'd1);
    step();
    bus.mem_done_in = 1'b1;
    bus.mem_data_in = 32'hDEAD_BEEF;
    step();
    bus.mem_done_in = 1'b0;
    check("flush_req_drop", {31'd0, bus.mem_req_out}, 32'd0);
    step();
    fetch(32'h0000_0010, 1'b1, 0);

    // Flush coincident with the memory response.
    bus.fetch_valid_in = 1'b1;
    bus.fetch_pc_in    = 32'h0000_0020;
    step();
    bus.fetch_valid_in = 1'b0;
    step();
    bus.mem_done_in = 1'b1;
    bus.mem_data_in = mem_word(32'h0000_0020);
    bus.clear_in    = 1'b1;
    step();
    bus.mem_done_in = 1'b0;
    bus.clear_in    = 1'b0;
    check("cdone_req_drop", {31'd0, bus.mem_req_out}, 32'd0);
    step();
    fetch(32'h0000_0020, 1'b1, 0);

    // Flush in idle drops a same-cycle request that would miss.
    bus.fetch_valid_in = 1'b1;
    bus.fetch_pc_in    = 32'h0000_0050;
    bus.clear_in       = 1'b1;
    step();
    bus.fetch_valid_in = 1'b0;
    bus.clear_in       = 1'b0;
    check("idle_clear_no_req", {31'd0, bus.mem_req_out}, 32'd0);
    check("idle_clear_ready", {31'd0, bus.ready_out}, 32'd1);
    step();

    // Pause during a miss; a response pulse while paused must be ignored.
    bus.fetch_valid_in = 1'b1;
    bus.fetch_pc_in    = 32'h0000_0030;
    step();
    bus.fetch_valid_in = 1'b0;
    step();
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mem_done_in = (i == 2);
      bus.mem_data_in = 32'h1234_5678;
      step();
      check("pause_req", {31'd0, bus.mem_req_out}, 32'd1);
      check("pause_ready", {31'd0, bus.ready_out}, 32'd0);
      check("pause_addr", bus.mem_addr_out, 32'h0000_0030);
    end
    bus.mem_done_in = 1'b0;
    rdy_in = 1'b1;
    step();
    check("resume_req", {31'd0, bus.mem_req_out}, 32'd1);
    check("resume_ready", {31'd0, bus.ready_out}, 32'd0);
    begin
      exp_t e;
      bus.mem_done_in = 1'b1;
      bus.mem_data_in = mem_word(32'h0000_0030);
      e.inst = bus.mem_data_in;
      e.pc   = 32'h0000_0030;
      sb.push_back(e);
    end
    step();
    bus.mem_done_in = 1'b0;
    check("resume_fill_done", {31'd0, bus.mem_req_out}, 32'd0);
    fetch(32'h0000_0030, 1'b1, 0);

    // Reset during a miss aborts it and invalidates every line.
    bus.fetch_valid_in = 1'b1;
    bus.fetch_pc_in    = 32'h0000_0040;
    step();
    bus.fetch_valid_in = 1'b0;
    step();
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
    check("mrst_req", {31'd0, bus.mem_req_out}, 32'd0);
    check("mrst_ready", {31'd0, bus.ready_out}, 32'd1);
    check("mrst_addr", bus.mem_addr_out, 32'd0);
    check("mrst_inst", bus.inst_out, 32'd0);
    check("mrst_inst_pc", bus.inst_pc_out, 32'd0);
    fetch(32'h0000_0000, 1'b0, 1);

    repeat (3) step();
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
